// File: rtl/sti_so_rx.sv
// Serial receive stage for the STI transmitter output: reassembles MSB-first
// bits into bytes, buffers them in a fall-through FIFO and tracks word stats.
module sti_so_rx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        so_data,
  input  logic        so_valid,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] byte_cnt,
  output logic [7:0]  word_cnt,
  output logic        overflow,
  output logic        frag_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          prev_valid_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]    word_cnt_q, word_cnt_d;
  logic          overflow_q, overflow_d;
  logic          frag_err_q, frag_err_d;

  logic          push_s;
  logic [7:0]    push_data_s;
  logic          pop_s;
  logic          accept_s;

  // Bit assembly, byte completion and word-end fragment handling
  always_comb begin
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    frag_err_d  = frag_err_q;
    push_s      = 1'b0;
    push_data_s = 8'h00;
    if (so_valid) begin
      sh_d      = {sh_q[6:0], so_data};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        push_s      = 1'b1;
        push_data_s = {sh_q[6:0], so_data};
      end else begin
        push_s      = 1'b0;
      end
    end else if (prev_valid_q) begin
      word_cnt_d = word_cnt_q + 8'd1;
      if (bit_cnt_q != 3'd0) begin
        // Partial byte: left-align the received bits, zero-pad below
        push_s      = 1'b1;
        push_data_s = sh_q << (4'd8 - {1'b0, bit_cnt_q});
        frag_err_d  = 1'b1;
        bit_cnt_d   = 3'd0;
      end else begin
        push_s      = 1'b0;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // FIFO bookkeeping; a pop frees the slot for a same-cycle push
  always_comb begin
    pop_s      = (cnt_q != '0) && m_ready;
    accept_s   = push_s && ((cnt_q < CW'(FIFO_DEPTH)) || pop_s);
    overflow_d = overflow_q | (push_s & ~accept_s);
    byte_cnt_d = byte_cnt_q + {15'd0, accept_s};
    wr_ptr_d   = accept_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_s    ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({accept_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q         <= 8'h00;
      bit_cnt_q    <= 3'd0;
      prev_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      byte_cnt_q   <= 16'd0;
      word_cnt_q   <= 8'd0;
      overflow_q   <= 1'b0;
      frag_err_q   <= 1'b0;
    end else begin
      sh_q         <= sh_d;
      bit_cnt_q    <= bit_cnt_d;
      prev_valid_q <= so_valid;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      overflow_q   <= overflow_d;
      frag_err_q   <= frag_err_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (accept_s) begin
      mem_q[wr_ptr_q] <= push_data_s;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign m_data   = mem_q[rd_ptr_q];
  assign m_valid  = (cnt_q != '0);
  assign byte_cnt = byte_cnt_q;
  assign word_cnt = word_cnt_q;
  assign overflow = overflow_q;
  assign frag_err = frag_err_q;

endmodule

// File: tb/tb_sti_so_rx.sv
// Directed self-checking bench for sti_so_rx (FIFO_DEPTH=4).
module tb_sti_so_rx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        so_data = 1'b0;
  logic        so_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic [15:0] byte_cnt;
  logic [7:0]  word_cnt;
  logic        overflow;
  logic        frag_err;

  int total = 0;
  int bad = 0;

  sti_so_rx #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .so_data(so_data), .so_valid(so_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .byte_cnt(byte_cnt), .word_cnt(word_cnt),
    .overflow(overflow), .frag_err(frag_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mv"},   {31'd0, m_valid},  32'd0);
    chk({tag, "_bc"},   {16'd0, byte_cnt}, 32'd0);
    chk({tag, "_wc"},   {24'd0, word_cnt}, 32'd0);
    chk({tag, "_ovf"},  {31'd0, overflow}, 32'd0);
    chk({tag, "_frag"}, {31'd0, frag_err}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; so_valid = 1'b0; so_data = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Sends n bits MSB first; optionally checks each completed byte the cycle
  // after its 8th bit and raises m_ready together with the final bit.
  task automatic send_word(input logic [39:0] v, input int n, input bit check, input bit rdy_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (check && i > 0 && (i % 8) == 0) begin
        chk("byte_mv", {31'd0, m_valid}, 32'd1);
        chk("byte_data", {24'd0, m_data}, {24'd0, v[n-i +: 8]});
      end
      if (rdy_last && i == n - 1) m_ready = 1'b1;
      so_valid = 1'b1;
      so_data  = v[n-1-i];
    end
    @(negedge clk);
    if (check && (n % 8) == 0) begin
      chk("byte_mv", {31'd0, m_valid}, 32'd1);
      chk("byte_data", {24'd0, m_data}, {24'd0, v[7:0]});
    end
    so_valid = 1'b0;
  endtask

  // Pops n bytes (first in v[8n-1 -: 8]) and expects the FIFO empty after.
  task automatic drain(input logic [39:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      chk("drain_mv", {31'd0, m_valid}, 32'd1);
      chk("drain_data", {24'd0, m_data}, {24'd0, v[8*(n-1-i) +: 8]});
      m_ready = 1'b1;
      @(negedge clk);
    end
    chk("drain_empty", {31'd0, m_valid}, 32'd0);
    m_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk); @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;

    // Single 8-bit word 0xA5 consumed immediately
    m_ready = 1'b1;
    send_word(40'hA5, 8, 1'b1, 1'b0);
    @(negedge clk);
    chk("a5_mv_gone", {31'd0, m_valid},  32'd0);
    chk("a5_bc",      {16'd0, byte_cnt}, 32'd1);
    chk("a5_wc",      {24'd0, word_cnt}, 32'd1);
    chk("a5_ovf",     {31'd0, overflow}, 32'd0);
    chk("a5_frag",    {31'd0, frag_err}, 32'd0);

    // 32-bit word, bytes emerge in order
    do_reset();
    m_ready = 1'b1;
    send_word(40'h12345678, 32, 1'b1, 1'b0);
    @(negedge clk);
    chk("w32_bc", {16'd0, byte_cnt}, 32'd4);
    chk("w32_wc", {24'd0, word_cnt}, 32'd1);
    chk("w32_mv", {31'd0, m_valid},  32'd0);

    // Backpressure: fifth byte dropped
    do_reset();
    send_word(40'h0102030405, 40, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_ovf", {31'd0, overflow}, 32'd1);
    chk("bp_bc",  {16'd0, byte_cnt}, 32'd4);
    chk("bp_wc",  {24'd0, word_cnt}, 32'd1);
    drain(40'h01020304, 4);

    // Fragment of 3 bits, then an intact 0xFF
    do_reset();
    send_word(40'h5, 3, 1'b0, 1'b0);
    @(negedge clk);
    chk("frag_flag", {31'd0, frag_err}, 32'd1);
    chk("frag_wc",   {24'd0, word_cnt}, 32'd1);
    chk("frag_bc",   {16'd0, byte_cnt}, 32'd1);
    drain(40'hA0, 1);
    send_word(40'hFF, 8, 1'b0, 1'b0);
    chk("ff_mv",   {31'd0, m_valid}, 32'd1);
    chk("ff_data", {24'd0, m_data},  32'hFF);
    @(negedge clk);
    chk("ff_wc",   {24'd0, word_cnt}, 32'd2);
    chk("ff_bc",   {16'd0, byte_cnt}, 32'd2);
    drain(40'hFF, 1);

    // Full FIFO with pop in the cycle the fifth byte completes
    do_reset();
    send_word(40'h1122334455, 40, 1'b0, 1'b1);
    m_ready = 1'b0;
    chk("fp_bc",   {16'd0, byte_cnt}, 32'd5);
    chk("fp_ovf",  {31'd0, overflow}, 32'd0);
    @(negedge clk);
    drain(40'h22334455, 4);

    // Asynchronous reset in the middle of a byte
    send_word(40'h77, 8, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      so_valid = 1'b1;
      so_data  = (i < 2) ? 1'b1 : 1'b0;
    end
    #2 reset = 1'b1;
    #1 chk_idle("async_rst");
    @(negedge clk);
    so_valid = 1'b0;
    reset = 1'b0;
    chk_idle("post_rst");
    send_word(40'h3C, 8, 1'b0, 1'b0);
    chk("rst_3c_mv",   {31'd0, m_valid},  32'd1);
    chk("rst_3c_data", {24'd0, m_data},   32'h3C);
    chk("rst_3c_bc",   {16'd0, byte_cnt}, 32'd1);
    @(negedge clk);
    chk("rst_3c_frag", {31'd0, frag_err}, 32'd0);
    chk("rst_3c_wc",   {24'd0, word_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
